// File: rtl/count_check_pkg.sv
// Shared types and constants for the count stream checker.
package count_check_pkg;

  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} cc_state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/count_checker_sync.sv
// Two-flop synchronizer used on the pin side of count_checker when COUNT_CHECK_SYNC_EN is defined.
module count_checker_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/count_checker.sv
// Receive-side checker for a free-running count stream: lock FSM, flywheel compare, saturating error total.
// Optional macro COUNT_CHECK_SYNC_EN adds a 2-flop synchronizer on count_in/valid_in (3 clk pin-to-status).
module count_checker
  import count_check_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOCK_LEN   = 4,
  parameter int UNLOCK_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count_in,
  input  logic             valid_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] last_count
);

  localparam int MW = $clog2(LOCK_LEN + 1);
  localparam int UW = $clog2(UNLOCK_LEN + 1);

  logic [WIDTH-1:0] s_count;
  logic             s_valid;

`ifdef COUNT_CHECK_SYNC_EN
  count_checker_sync #(.W(WIDTH + 1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({valid_in, count_in}),
    .q     ({s_valid, s_count})
  );
`else
  assign s_count = count_in;
  assign s_valid = valid_in;
`endif

  cc_state_t        state, state_nx;
  logic [WIDTH-1:0] expected, expected_nx, last_nx;
  logic [MW-1:0]    match_cnt, match_nx;
  logic [UW-1:0]    miss_cnt, miss_nx;
  logic             err_pulse_nx;
  logic [7:0]       err_count_nx, err_base;
  logic             hit;

  assign hit    = (s_count == expected);
  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HUNT;
      expected   <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      last_count <= '0;
    end else begin
      state      <= state_nx;
      expected   <= expected_nx;
      match_cnt  <= match_nx;
      miss_cnt   <= miss_nx;
      err_pulse  <= err_pulse_nx;
      err_count  <= err_count_nx;
      last_count <= last_nx;
    end
  end

  // Clear is applied before any new error so clear+error in one cycle yields a count of 1.
  always_comb begin
    state_nx     = state;
    expected_nx  = expected;
    match_nx     = match_cnt;
    miss_nx      = miss_cnt;
    err_pulse_nx = 1'b0;
    last_nx      = last_count;
    err_base     = clr_err ? 8'd0 : err_count;
    err_count_nx = err_base;

    if (s_valid) begin
      last_nx = s_count;
      unique case (state)
        HUNT: begin
          expected_nx = s_count + 1'b1;
          match_nx    = '0;
          state_nx    = ACQUIRE;
        end
        ACQUIRE: begin
          if (hit) begin
            match_nx    = match_cnt + 1'b1;
            expected_nx = expected + 1'b1;
            if (int'(match_cnt) + 1 == LOCK_LEN) begin
              state_nx = LOCKED;
              miss_nx  = '0;
            end
          end else begin
            expected_nx = s_count + 1'b1;
            match_nx    = '0;
          end
        end
        LOCKED: begin
          // Flywheel: keep advancing the expectation rather than resyncing to a bad sample.
          expected_nx = expected + 1'b1;
          if (hit) begin
            miss_nx = '0;
          end else begin
            err_pulse_nx = 1'b1;
            if (err_base != ERR_CNT_MAX) err_count_nx = err_base + 8'd1;
            miss_nx = miss_cnt + 1'b1;
            if (int'(miss_cnt) + 1 == UNLOCK_LEN) state_nx = HUNT;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// Table-driven bench for count_checker; clr_err is skewed to line up with the synchronized data path.
module tb_count_checker;

`ifdef COUNT_CHECK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] count_in;
  logic       valid_in;
  logic       clr_err;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [7:0] last_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       valid;
    logic [7:0] cnt;
    logic       clr;
    logic       chk;
    logic       lk;
    logic       pulse;
    logic [7:0] errs;
    logic [7:0] last;
  } vec_t;

  vec_t vec[$];

  count_checker #(.WIDTH(8), .LOCK_LEN(4), .UNLOCK_LEN(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_in   (count_in),
    .valid_in   (valid_in),
    .clr_err    (clr_err),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .last_count (last_count)
  );

  always #5 clk = ~clk;

  function automatic void addRow(input logic v, input logic [7:0] c, input logic clr,
                                 input logic chk, input logic lk, input logic p,
                                 input logic [7:0] e, input logic [7:0] last);
    vec_t r;
    r.valid = v; r.cnt = c; r.clr = clr; r.chk = chk;
    r.lk = lk; r.pulse = p; r.errs = e; r.last = last;
    vec.push_back(r);
  endfunction

  task automatic checkOutput(input string tag, input int idx, input logic lk, input logic p,
                             input logic [7:0] e, input logic [7:0] last);
    total += 4;
    if (locked !== lk) begin
      bad++;
      $display("[TB] FAIL %s[%0d] locked got %0b want %0b", tag, idx, locked, lk);
    end
    if (err_pulse !== p) begin
      bad++;
      $display("[TB] FAIL %s[%0d] err_pulse got %0b want %0b", tag, idx, err_pulse, p);
    end
    if (err_count !== e) begin
      bad++;
      $display("[TB] FAIL %s[%0d] err_count got %0d want %0d", tag, idx, err_count, e);
    end
    if (last_count !== last) begin
      bad++;
      $display("[TB] FAIL %s[%0d] last_count got %02h want %02h", tag, idx, last_count, last);
    end
  endtask

  // Drive the queued rows one per cycle and compare each row LAT edges after its data is presented.
  task automatic applyStimulus(input string tag);
    int n;
    n = vec.size();
    for (int s = 0; s < n + LAT - 1; s++) begin
      int c;
      c = s - (LAT - 1);
      if (s < n) begin
        valid_in = vec[s].valid;
        count_in = vec[s].cnt;
      end else begin
        valid_in = 1'b0;
        count_in = 8'h00;
      end
      clr_err = (c >= 0 && c < n) ? vec[c].clr : 1'b0;
      @(posedge clk);
      #1;
      if (c >= 0 && vec[c].chk)
        checkOutput(tag, c, vec[c].lk, vec[c].pulse, vec[c].errs, vec[c].last);
    end
    valid_in = 1'b0;
    clr_err  = 1'b0;
    vec.delete();
  endtask

  task automatic pulseReset(input string tag);
    valid_in = 1'b0;
    clr_err  = 1'b0;
    count_in = 8'h00;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput(tag, 0, 1'b0, 1'b0, 8'd0, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] ex;
    logic [7:0] wrong;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    clr_err  = 1'b0;
    count_in = 8'h00;
    $display("[TB] count_checker bench, latency %0d", LAT);
    repeat (2) @(posedge clk);
    pulseReset("reset");

    // Lock near the top of the range, then run through the wrap.
    addRow(1, 8'hFA, 0, 1, 0, 0, 0, 8'hFA);
    addRow(1, 8'hFB, 0, 1, 0, 0, 0, 8'hFB);
    addRow(1, 8'hFC, 0, 1, 0, 0, 0, 8'hFC);
    addRow(1, 8'hFD, 0, 1, 0, 0, 0, 8'hFD);
    addRow(1, 8'hFE, 0, 1, 1, 0, 0, 8'hFE);
    addRow(1, 8'hFF, 0, 1, 1, 0, 0, 8'hFF);
    addRow(1, 8'h00, 0, 1, 1, 0, 0, 8'h00);
    addRow(1, 8'h01, 0, 1, 1, 0, 0, 8'h01);
    addRow(1, 8'h02, 0, 1, 1, 0, 0, 8'h02);
    for (int c = 3; c <= 10; c++) addRow(1, 8'(c), 0, 1, 1, 0, 0, 8'(c));
    addRow(1, 8'd11, 0, 1, 1, 0, 0, 8'd11);
    addRow(1, 8'd99, 0, 1, 1, 1, 1, 8'd99);
    addRow(1, 8'd13, 0, 1, 1, 0, 1, 8'd13);
    addRow(0, 8'h00, 0, 1, 1, 0, 1, 8'd13);
    addRow(1, 8'h50, 0, 1, 1, 1, 2, 8'h50);
    addRow(0, 8'h00, 0, 1, 1, 0, 2, 8'h50);
    addRow(1, 8'h50, 0, 1, 1, 1, 3, 8'h50);
    addRow(1, 8'h50, 0, 1, 0, 1, 4, 8'h50);
    addRow(1, 8'h20, 0, 1, 0, 0, 4, 8'h20);
    addRow(1, 8'h21, 0, 1, 0, 0, 4, 8'h21);
    addRow(1, 8'h22, 0, 1, 0, 0, 4, 8'h22);
    addRow(1, 8'h23, 0, 1, 0, 0, 4, 8'h23);
    addRow(1, 8'h24, 0, 1, 1, 0, 4, 8'h24);
    addRow(0, 8'h00, 1, 1, 1, 0, 0, 8'h24);
    addRow(1, 8'h00, 0, 1, 1, 1, 1, 8'h00);
    addRow(1, 8'h00, 0, 1, 1, 1, 2, 8'h00);
    addRow(1, 8'h00, 0, 1, 0, 1, 3, 8'h00);
    addRow(1, 8'h40, 0, 1, 0, 0, 3, 8'h40);
    addRow(1, 8'h41, 0, 1, 0, 0, 3, 8'h41);
    addRow(1, 8'h99, 0, 1, 0, 0, 3, 8'h99);
    addRow(1, 8'h9A, 0, 1, 0, 0, 3, 8'h9A);
    addRow(1, 8'h9B, 0, 1, 0, 0, 3, 8'h9B);
    addRow(1, 8'h9C, 0, 1, 0, 0, 3, 8'h9C);
    addRow(1, 8'h9D, 0, 1, 1, 0, 3, 8'h9D);
    addRow(1, 8'h00, 1, 1, 1, 1, 1, 8'h00);
    addRow(0, 8'h00, 0, 1, 1, 0, 1, 8'h00);
    applyStimulus("stream");

    pulseReset("midreset");

    addRow(1, 8'h30, 0, 1, 0, 0, 0, 8'h30);
    addRow(1, 8'h31, 0, 1, 0, 0, 0, 8'h31);
    addRow(1, 8'h32, 0, 1, 0, 0, 0, 8'h32);
    addRow(1, 8'h33, 0, 1, 0, 0, 0, 8'h33);
    addRow(1, 8'h34, 0, 1, 1, 0, 0, 8'h34);
    applyStimulus("relock");

    // Alternate bad/good samples so the lock holds while the error total climbs to saturation.
    pulseReset("satreset");
    for (int c = 0; c < 4; c++) addRow(1, 8'(c), 0, 0, 0, 0, 0, 8'(c));
    addRow(1, 8'h04, 0, 1, 1, 0, 0, 8'h04);
    ex = 8'h05;
    for (int k = 0; k < 255; k++) begin
      wrong = ex ^ 8'h80;
      addRow(1, wrong, 0, (k == 254), 1, 1, 8'd255, wrong);
      ex = ex + 8'd1;
      addRow(1, ex, 0, 0, 1, 0, 0, ex);
      ex = ex + 8'd1;
    end
    wrong = ex ^ 8'h80;
    addRow(1, wrong, 0, 1, 1, 1, 8'd255, wrong);
    ex = ex + 8'd1;
    addRow(1, ex, 0, 1, 1, 0, 8'd255, ex);
    ex = ex + 8'd1;
    wrong = ex ^ 8'h80;
    addRow(1, wrong, 1, 1, 1, 1, 8'd1, wrong);
    applyStimulus("saturate");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
